// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port, 1-cycle-latency memory between instruction fetch and data access.
// Data wins contested cycles unless fetch has been denied MAX_WAIT times in a row.
module imem_dmem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [DATA_WIDTH-1:0] i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic [DATA_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic                  d_we0,
  input  logic                  d_we1,
  input  logic                  d_we2,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic [DATA_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic                  m_we0,
  output logic                  m_we1,
  output logic                  m_we2,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  output logic [3:0]            starve_cnt
);

  // Handshake: a requester holds req (and its address/data/enables) until the
  // cycle its gnt is high; the response, if any, is the cycle after with rvalid=1.

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_INST  = 2'd1,
    OWN_DREAD = 2'd2
  } owner_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  owner_t                r_owner;
  logic [3:0]            r_starve;
  logic [DATA_WIDTH-1:0] r_last_addr;
  logic [DATA_WIDTH-1:0] r_i_rdata;
  logic [DATA_WIDTH-1:0] r_d_rdata;

  logic w_i_gnt;
  logic w_d_gnt;
  logic w_d_store;
  logic w_i_route;
  logic w_d_route;

  assign w_d_store = d_we0 | d_we1 | d_we2;

  always_comb begin
    w_i_gnt = 1'b0;
    w_d_gnt = 1'b0;
    if (rst) begin
      if (i_req && (!d_req || (r_starve >= MAX_WAIT_C))) begin
        w_i_gnt = 1'b1;
      end else if (d_req) begin
        w_d_gnt = 1'b1;
      end
    end
  end

  assign i_gnt = w_i_gnt;
  assign d_gnt = w_d_gnt;

  always_comb begin
    m_addr = r_last_addr;
    if (w_i_gnt) begin
      m_addr = i_addr;
    end else if (w_d_gnt) begin
      m_addr = d_addr;
    end
  end

  assign m_wdata = w_d_gnt ? d_wdata : '0;
  assign m_we0   = w_d_gnt & d_we0;
  assign m_we1   = w_d_gnt & d_we1;
  assign m_we2   = w_d_gnt & d_we2;

  // Gating with rst drops a response whose grant preceded a reset cycle.
  assign w_i_route = rst && (r_owner == OWN_INST);
  assign w_d_route = rst && (r_owner == OWN_DREAD);

  assign i_rvalid = w_i_route;
  assign d_rvalid = w_d_route;
  assign i_rdata  = w_i_route ? m_rdata : r_i_rdata;
  assign d_rdata  = w_d_route ? m_rdata : r_d_rdata;

  assign starve_cnt = r_starve;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_owner     <= OWN_NONE;
      r_starve    <= 4'd0;
      r_last_addr <= '0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
    end else begin
      if (w_i_gnt) begin
        r_owner <= OWN_INST;
      end else if (w_d_gnt && !w_d_store) begin
        r_owner <= OWN_DREAD;
      end else begin
        r_owner <= OWN_NONE;
      end

      if (i_req && !w_i_gnt) begin
        if (r_starve != 4'd15) begin
          r_starve <= r_starve + 4'd1;
        end
      end else begin
        r_starve <= 4'd0;
      end

      if (w_i_gnt || w_d_gnt) begin
        r_last_addr <= m_addr;
      end
      if (w_i_route) begin
        r_i_rdata <= m_rdata;
      end
      if (w_d_route) begin
        r_d_rdata <= m_rdata;
      end
    end
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter with a small memory model and response scoreboard.
module tb_imem_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_we0;
  logic        d_we1;
  logic        d_we2;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_we0;
  logic        m_we1;
  logic        m_we2;
  logic [31:0] m_rdata;
  logic [3:0]  starve_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_i_q[$];
  logic [31:0] exp_d_q[$];

  imem_dmem_arbiter #(.DATA_WIDTH(32), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_we0(d_we0), .d_we1(d_we1), .d_we2(d_we2),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_we0(m_we0), .m_we1(m_we1), .m_we2(m_we2),
    .m_rdata(m_rdata), .starve_cnt(starve_cnt)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: 64 words, reloaded with 0xA5A5_00xx on every reset edge
  logic [31:0] mem [0:63];

  function automatic logic [5:0] idx(input logic [31:0] a);
    return {a[15], a[6:2]};
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 64; k++) mem[k] <= 32'hA5A5_0000 | 32'(k);
    end else if (m_we2) begin
      mem[idx(m_addr)] <= m_wdata;
    end else if (m_we1) begin
      mem[idx(m_addr)][15:0] <= m_wdata[15:0];
    end else if (m_we0) begin
      mem[idx(m_addr)][7:0] <= m_wdata[7:0];
    end
    m_rdata <= mem[idx(m_addr)];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (i_rvalid) begin
      if (exp_i_q.size() == 0) check("i_unexpected_rvalid", 32'd1, 32'd0);
      else check("i_rdata", i_rdata, exp_i_q.pop_front());
    end
    if (d_rvalid) begin
      if (exp_d_q.size() == 0) check("d_unexpected_rvalid", 32'd1, 32'd0);
      else check("d_rdata", d_rdata, exp_d_q.pop_front());
    end
  end

  logic [31:0] alt_addr [0:4];
  logic [31:0] alt_exp  [0:4];
  logic        alt_is_i [0:4];

  initial begin
    rst = 1'b0; i_req = 1'b1; i_addr = 32'h0000_004C;
    d_req = 1'b0; d_addr = '0; d_wdata = '0; d_we0 = 1'b0; d_we1 = 1'b0; d_we2 = 1'b0;

    // Reset: grants forced low, outputs cleared
    @(negedge clk);
    check("gnt_in_reset", {31'd0, i_gnt}, 32'd0);
    @(negedge clk);
    check("rst_i_rvalid", {31'd0, i_rvalid}, 32'd0);
    check("rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    check("rst_i_rdata", i_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_starve", {28'd0, starve_cnt}, 32'd0);

    // First fetch after reset
    next_cycle(); rst = 1'b1;
    @(negedge clk);
    check("fetch_gnt", {31'd0, i_gnt}, 32'd1);
    check("fetch_m_addr", m_addr, 32'h0000_004C);
    exp_i_q.push_back(32'hA5A5_0013);
    next_cycle(); i_req = 1'b0;
    @(negedge clk);
    check("fetch_rvalid", {31'd0, i_rvalid}, 32'd1);
    check("fetch_no_d_rvalid", {31'd0, d_rvalid}, 32'd0);

    // Contention: four data grants, then fetch wins
    next_cycle(); i_req = 1'b1; i_addr = 32'h0; d_req = 1'b1; d_addr = 32'h0000_C000;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("starve_cnt", {28'd0, starve_cnt}, 32'(c % 5));
      if ((c % 5) < 4) begin
        check("starve_d_gnt", {30'd0, i_gnt, d_gnt}, 32'd1);
        exp_d_q.push_back(32'hA5A5_0020);
      end else begin
        check("starve_i_gnt", {30'd0, i_gnt, d_gnt}, 32'd2);
        exp_i_q.push_back(32'hA5A5_0000);
      end
      if (c < 9) next_cycle();
    end

    // Reset right after a fetch grant drops its response
    next_cycle(); d_req = 1'b0; i_addr = 32'h0000_004C;
    @(negedge clk);
    check("pre_rst_i_gnt", {31'd0, i_gnt}, 32'd1);
    next_cycle(); rst = 1'b0;
    @(negedge clk);
    check("midrst_i_rvalid", {31'd0, i_rvalid}, 32'd0);
    check("midrst_i_gnt", {31'd0, i_gnt}, 32'd0);
    check("midrst_starve", {28'd0, starve_cnt}, 32'd0);
    next_cycle();
    @(negedge clk);
    check("midrst2_i_gnt", {31'd0, i_gnt}, 32'd0);
    check("midrst2_starve", {28'd0, starve_cnt}, 32'd0);
    next_cycle(); rst = 1'b1;
    @(negedge clk);
    check("reissue_i_gnt", {31'd0, i_gnt}, 32'd1);
    exp_i_q.push_back(32'hA5A5_0013);

    // Word store then load back
    next_cycle(); i_req = 1'b0;
    d_req = 1'b1; d_addr = 32'h0000_C000; d_wdata = 32'hDEAD_BEEF; d_we2 = 1'b1;
    @(negedge clk);
    check("store_d_gnt", {31'd0, d_gnt}, 32'd1);
    check("store_m_we", {29'd0, m_we2, m_we1, m_we0}, 32'd4);
    check("store_m_addr", m_addr, 32'h0000_C000);
    check("store_m_wdata", m_wdata, 32'hDEAD_BEEF);
    next_cycle(); d_we2 = 1'b0;
    @(negedge clk);
    check("store_no_rvalid", {31'd0, d_rvalid}, 32'd0);
    check("load_d_gnt", {31'd0, d_gnt}, 32'd1);
    exp_d_q.push_back(32'hDEAD_BEEF);

    // Byte store contending with fetch
    next_cycle(); d_addr = 32'h0000_C004; d_wdata = 32'h0000_00AA; d_we0 = 1'b1;
    i_req = 1'b1; i_addr = 32'h0000_0008;
    @(negedge clk);
    check("byte_gnts", {30'd0, i_gnt, d_gnt}, 32'd1);
    check("byte_m_we", {29'd0, m_we2, m_we1, m_we0}, 32'd1);
    check("byte_m_wdata", m_wdata, 32'h0000_00AA);
    next_cycle(); d_req = 1'b0; d_we0 = 1'b0;
    @(negedge clk);
    check("byte_then_i_gnt", {31'd0, i_gnt}, 32'd1);
    exp_i_q.push_back(32'hA5A5_0002);
    next_cycle(); i_req = 1'b0; d_req = 1'b1; d_addr = 32'h0000_C004;
    @(negedge clk);
    check("fetch_rvalid_2cyc", {31'd0, i_rvalid}, 32'd1);
    check("byte_load_gnt", {31'd0, d_gnt}, 32'd1);
    exp_d_q.push_back(32'hA5A5_00AA);

    // Alternating fetch / load grants
    alt_is_i = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    alt_addr = '{32'h0, 32'hC000, 32'h4, 32'hC004, 32'h8};
    alt_exp  = '{32'hA5A5_0000, 32'hDEAD_BEEF, 32'hA5A5_0001, 32'hA5A5_00AA, 32'hA5A5_0002};
    for (int j = 0; j < 5; j++) begin
      next_cycle();
      i_req = alt_is_i[j]; d_req = ~alt_is_i[j];
      i_addr = alt_addr[j]; d_addr = alt_addr[j];
      @(negedge clk);
      check("alt_gnts", {30'd0, i_gnt, d_gnt}, alt_is_i[j] ? 32'd2 : 32'd1);
      if (alt_is_i[j]) exp_i_q.push_back(alt_exp[j]);
      else exp_d_q.push_back(alt_exp[j]);
      if (j == 2) begin
        check("alt_d_rvalid", {31'd0, d_rvalid}, 32'd1);
        check("i_rdata_hold", i_rdata, 32'hA5A5_0000);
      end
    end
    next_cycle(); i_req = 1'b0; d_req = 1'b0;
    repeat (3) @(negedge clk);
    check("i_queue_empty", 32'(exp_i_q.size()), 32'd0);
    check("d_queue_empty", 32'(exp_d_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-port, 1-cycle-read-latency memory between the rv32i instruction-fetch port and the data port.
- Sits between the core (iaddr/idin, daddr/ddout/ddin/dwe0-2) and a single-port dmem.
- Uses req/gnt handshakes and fixed data-over-instruction priority, with a starvation guard for fetch.
- Response data is routed back by a registered owner tag.

Parameters:
- DATA_WIDTH, 32, width of addresses and data on all ports.
- MAX_WAIT, 4, number of consecutive denied fetch cycles after which fetch wins the next contested cycle (legal range 1..15).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- i_req  in  1  fetch request; held until i_gnt.
- i_addr  in  DATA_WIDTH  fetch address.
- i_gnt  out  1  fetch accepted this cycle.
- i_rvalid  out  1  i_rdata valid (the cycle after i_gnt).
- i_rdata  out  DATA_WIDTH  fetched word.
- d_req  in  1  data request; held until d_gnt.
- d_addr  in  DATA_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  store data.
- d_we0  in  1  byte store.
- d_we1  in  1  halfword store.
- d_we2  in  1  word store.
- d_gnt  out  1  data access accepted this cycle.
- d_rvalid  out  1  d_rdata valid (loads only, the cycle after d_gnt).
- d_rdata  out  DATA_WIDTH  load data.
- m_addr  out  DATA_WIDTH  memory address.
- m_wdata  out  DATA_WIDTH  memory write data.
- m_we0  out  1  memory byte write enable.
- m_we1  out  1  memory halfword write enable.
- m_we2  out  1  memory word write enable.
- m_rdata  in  DATA_WIDTH  memory read data (valid 1 cycle after address).
- starve_cnt  out  4  current consecutive fetch-denial count, for debug.

Behaviour:
- Reset (rst=0 at an edge):
  - owner register = NONE; starve counter = 0.
  - i_rvalid = d_rvalid = 0.
  - i_rdata and d_rdata = 0.
  - Combinational grants are forced to 0 while rst=0.
  - A grant in the same cycle as reset is void; no response follows it.
- Grant decision (combinational, every cycle):
  - d_req only: grant data.
  - i_req only: grant fetch.
  - Both requesting: grant data, unless starve counter >= MAX_WAIT, in which case grant fetch.
  - Neither requesting: no grant; m_we* = 0; m_addr holds the last granted address.
- Memory drive: m_addr/m_wdata come from the granted requester.
  - m_weN = d_weN only when data is granted; otherwise all 0.
  - Fetch grants never write.
- Owner register (next state): INST if fetch granted, DREAD if a data load was granted (all d_we* = 0), else NONE.
  - Stores give owner NONE: accepted at d_gnt, no response.
- Response routing:
  - owner=INST: i_rvalid=1, i_rdata=m_rdata.
  - owner=DREAD: d_rvalid=1, d_rdata=m_rdata.
  - rvalid is registered; rdata is a registered copy of the routing select feeding a mux on m_rdata, so data appears in the rvalid cycle.
  - Unowned rdata ports hold their last value.
- Throughput: one grant per cycle, back-to-back; a response and a new grant may coincide.
- Starve counter:
  - Increments (saturating at 15) when i_req=1 and fetch not granted.
  - Clears when fetch is granted or i_req=0.
- Illegal stimulus: more than one d_we* high is illegal; the arbiter passes it through unchanged.
- Requester rule: address, data and enables are stable while req=1 and gnt=0.
- Reset mid-transfer: a pending response is dropped (rvalid never asserts); requesters reissue.
- No combinational path from m_rdata to any gnt.

Test Plan:
- Reset then i_req=1, i_addr=0x0000_004C, d_req=0 -> i_gnt=1 in the same cycle; next cycle i_rvalid=1 and i_rdata = mem[0x4C]; d_rvalid stays 0.
- Both requesting every cycle, d_req a load stream, MAX_WAIT=4 -> d_gnt for 4 cycles (starve_cnt 1,2,3,4), then i_gnt in cycle 5, starve_cnt back to 0; pattern repeats.
- d_req store, d_addr=0xC000, d_wdata=0xDEADBEEF, d_we2=1 -> d_gnt=1, m_we2=1, no d_rvalid; a following load of 0xC000 returns 0xDEADBEEF one cycle after its d_gnt.
- d_we0=1 with d_wdata=0x000000AA while i_req is also high -> data granted, m_we0=1, m_we1=m_we2=0; fetch is granted next cycle; i_rvalid appears 2 cycles after the initial request.
- Fetch granted at cycle N, rst=0 at cycle N+1 -> i_rvalid=0 at N+1; starve_cnt=0 and no grant until rst=1.
- Alternating fetch and load grants on consecutive cycles -> i_rvalid and d_rvalid alternate with no lost or misrouted data (fetch addr 0x0, 0x4, 0x8 interleaved with loads of 0xC000, 0xC004).
